cdc_fifo_wptr_full: RTL and testbench
=====================================

CDC_FIFO_WPTR_FULL -- requirements
Module: cdc_fifo_wptr_full

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, which is the FIFO address width; DEPTH = 2^ADDRSIZE.
REQ-002 The block SHALL have parameter AF_LEVEL, default 14, which is the almost-full occupancy threshold; legal range 1..DEPTH.
REQ-003 The block SHALL have port wr_clk, input, 1 bit: the write-domain clock; the block uses only this clock.
REQ-004 The block SHALL have port wr_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write request; it is the same signal as wr_clken at the FIFO memory.
REQ-006 The block SHALL have port rd_ptr_gray, input, ADDRSIZE+1 bits: Gray-coded read pointer from the read clock domain; it is asynchronous to wr_clk.
REQ-007 The block SHALL have port wr_addr, output, ADDRSIZE bits: memory write address, registered.
REQ-008 The block SHALL have port wr_ptr_gray, output, ADDRSIZE+1 bits: Gray-coded write pointer for the read domain, registered.
REQ-009 The block SHALL have port wr_full, output, 1 bit: FIFO full, registered; it drives wr_full at the memory.
REQ-010 The block SHALL have port wr_almost_full, output, 1 bit: occupancy >= AF_LEVEL, registered.
REQ-011 The block SHALL have port wr_level, output, ADDRSIZE+1 bits: occupancy as seen from the write side, registered, range 0..DEPTH.
REQ-012 The block SHALL have port wr_overflow, output, 1 bit: one-cycle pulse on a write attempt while full, registered.

Function
REQ-013 push = wr_en AND NOT wr_full, evaluated from the current registered wr_full.
REQ-014 The block SHALL hold an ADDRSIZE+1 bit binary write pointer wbin; wbin_next = wbin + push, modulo 2^(ADDRSIZE+1), wrapping from all-ones to zero.
REQ-015 wr_addr SHALL equal wbin[ADDRSIZE-1:0]; wr_ptr_gray SHALL be registered as (wbin_next >> 1) XOR wbin_next.
REQ-016 wr_ptr_gray SHALL change by at most one bit per clock and SHALL come directly from a flop, with no combinational logic after the flop.
REQ-017 rd_ptr_gray SHALL pass through a two-flop synchronizer (rq1, then rq2) before use; no other logic may sample rd_ptr_gray.
REQ-018 rbin_sync = Gray-to-binary conversion of rq2.
REQ-019 level_next = (wbin_next - rbin_sync) modulo 2^(ADDRSIZE+1); wr_level is registered from level_next.
REQ-020 wr_full SHALL be registered as 1 exactly when wr_ptr_gray_next equals rq2 with its two MSBs inverted; this is equivalent to level_next == DEPTH.
REQ-021 wr_almost_full SHALL be registered as (level_next >= AF_LEVEL).
REQ-022 wr_overflow SHALL be registered as (wr_en AND wr_full); on that cycle wbin, wr_addr and wr_ptr_gray SHALL stay unchanged.
REQ-023 Write latency: a push at clock edge k SHALL make wr_addr, wr_ptr_gray, wr_level and wr_full reflect the new pointer immediately after edge k.
REQ-024 Read-pointer latency: if rd_ptr_gray changes before edge N, wr_level, wr_full and wr_almost_full SHALL reflect the change after edge N+2, and not earlier.
REQ-025 If a push and a synchronized read-pointer advance occur in the same cycle, level_next SHALL include both, so wr_level is unchanged and wr_full is not asserted.
REQ-026 wr_full SHALL be pessimistic: it may stay asserted for up to 3 cycles after the read domain frees an entry, but it SHALL never be deasserted while DEPTH entries are actually occupied.

Reset
REQ-027 While wr_rst_n = 0, the following SHALL be 0 immediately and without needing a clock edge: wbin, rq1, rq2, wr_addr, wr_ptr_gray, wr_level, wr_full, wr_almost_full, wr_overflow.
REQ-028 Reset deassertion SHALL be acted on at the next wr_clk edge; the first push may occur on the first edge after deassertion.
REQ-029 Reset asserted mid-operation SHALL discard the pointer state.

Verification
REQ-030 The bench SHALL cover fill to full (ADDRSIZE=4, rd_ptr_gray=0): reset, then 16 writes on consecutive cycles -> wr_full=1 after the 16th edge, wr_level=16, wr_addr=0, wr_ptr_gray=5'b11000.
REQ-031 The bench SHALL cover overflow: from full, wr_en=1 for 1 cycle -> wr_overflow=1 for exactly 1 cycle, wr_ptr_gray stays 5'b11000, wr_level stays 16.
REQ-032 The bench SHALL cover release from full: while full, set rd_ptr_gray=5'b00001 before edge N -> wr_full=1 through edge N+1, wr_full=0 and wr_level=15 after edge N+2.
REQ-033 The bench SHALL cover almost-full (AF_LEVEL=14): 13 writes -> wr_almost_full=0; 14th write -> wr_almost_full=1 after that edge, wr_level=14.
REQ-034 The bench SHALL cover wrap-around: 40 writes with the read pointer trailing by at most 4 entries -> wr_ptr_gray=5'b01100 (binary 8), wr_addr=8, wr_full never asserted, and every wr_ptr_gray transition changes exactly 1 bit.
REQ-035 The bench SHALL cover reset mid-operation: at wr_level=10, drive wr_rst_n low between clock edges -> all outputs 0 before the next edge; after release, the first write yields wr_addr=1 and wr_level=1 (with rd_ptr_gray=0).

Source files
------------

// File: rtl/cdc_fifo_wptr_full.sv
// Write-side pointer and full logic for an asynchronous FIFO.
// Holds the binary write pointer and publishes its Gray-coded form to the read domain.
// Brings the read pointer in through a two-flop synchronizer.
// Derives registered occupancy, full, almost-full and overflow flags from both pointers.
// Flags depending on the read pointer lag the read domain by two write clocks.
// Because of that lag, full is pessimistic: it can clear late, but never early.
module cdc_fifo_wptr_full #(
    parameter int ADDRSIZE = 4,
    parameter int AF_LEVEL = 14
) (
    input  logic                wr_clk,
    input  logic                wr_rst_n,
    input  logic                wr_en,
    input  logic [ADDRSIZE:0]   rd_ptr_gray,
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic [ADDRSIZE:0]   wr_ptr_gray,
    output logic                wr_full,
    output logic                wr_almost_full,
    output logic [ADDRSIZE:0]   wr_level,
    output logic                wr_overflow
);

    localparam logic [ADDRSIZE:0] AF_THRESH = (ADDRSIZE+1)'(AF_LEVEL);

    // State registers
    logic [ADDRSIZE:0] wbin_q;
    logic [ADDRSIZE:0] wgray_q;
    logic [ADDRSIZE:0] rq1_q;
    logic [ADDRSIZE:0] rq2_q;
    logic [ADDRSIZE:0] level_q;
    logic              full_q;
    logic              afull_q;
    logic              ovf_q;

    // Next-state values
    logic              push;
    logic [ADDRSIZE:0] wbin_d;
    logic [ADDRSIZE:0] wgray_d;
    logic [ADDRSIZE:0] rbin_sync;
    logic [ADDRSIZE:0] level_d;
    logic [ADDRSIZE:0] rq2_full_cmp;
    logic              full_d;
    logic              afull_d;
    logic              ovf_d;

    // Gray-to-binary of the synchronized read pointer.
    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_rbin
        assign rbin_sync[gi] = ^rq2_q[ADDRSIZE:gi];
    end

    // A write is accepted only when the registered full flag is clear.
    assign push    = wr_en & ~full_q;
    assign wbin_d  = wbin_q + (ADDRSIZE+1)'(push);
    assign wgray_d = (wbin_d >> 1) ^ wbin_d;
    assign level_d = wbin_d - rbin_sync;

    // Full means the write pointer is exactly one lap ahead of the read pointer.
    // In Gray code, that is the read pointer with its top two bits inverted.
    assign rq2_full_cmp = {~rq2_q[ADDRSIZE:ADDRSIZE-1], rq2_q[ADDRSIZE-2:0]};
    assign full_d       = (wgray_d == rq2_full_cmp);
    assign afull_d      = (level_d >= AF_THRESH);
    assign ovf_d        = wr_en & full_q;

    // All write-side state, including the read-pointer synchronizer.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= rd_ptr_gray;
            rq2_q   <= rq1_q;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from flops.
    // The Gray pointer crosses domains, so no logic may sit after its flop.
    assign wr_addr        = wbin_q[ADDRSIZE-1:0];
    assign wr_ptr_gray    = wgray_q;
    assign wr_level       = level_q;
    assign wr_full        = full_q;
    assign wr_almost_full = afull_q;
    assign wr_overflow    = ovf_q;

endmodule

// File: tb/tb_cdc_fifo_wptr_full.sv
// Directed bench for cdc_fifo_wptr_full (ADDRSIZE=4, AF_LEVEL=14).
// Expected outputs come from an occupancy-count reference.
// Each expected output is queued when a step is driven, then popped after the edge.
module tb_cdc_fifo_wptr_full;

    logic       wr_clk;
    logic       wr_rst_n;
    logic       wr_en;
    logic [4:0] rd_ptr_gray;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic       wr_full;
    logic       wr_almost_full;
    logic [4:0] wr_level;
    logic       wr_overflow;

    cdc_fifo_wptr_full #(.ADDRSIZE(4), .AF_LEVEL(14)) dut (
        .wr_clk        (wr_clk),
        .wr_rst_n      (wr_rst_n),
        .wr_en         (wr_en),
        .rd_ptr_gray   (rd_ptr_gray),
        .wr_addr       (wr_addr),
        .wr_ptr_gray   (wr_ptr_gray),
        .wr_full       (wr_full),
        .wr_almost_full(wr_almost_full),
        .wr_level      (wr_level),
        .wr_overflow   (wr_overflow)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [3:0] addr;
        logic [4:0] gray;
        logic [4:0] level;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: accepted-write count and read count as plain integers.
    // The read count is delayed by two edges, standing in for the synchronizer.
    int m_wcnt;
    int m_r1;
    int m_r2;
    bit m_full;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_wcnt = 0;
        m_r1   = 0;
        m_r2   = 0;
        m_full = 0;
        sb.delete();
    endtask

    // Drive one cycle, queue the reference result, then pop and compare it after the edge.
    task automatic step(input logic en, input int rbin);
        exp_t e;
        exp_t got;
        int   wnext;
        int   occ;
        wr_en       = en;
        rd_ptr_gray = to_gray(rbin);
        wnext  = (m_wcnt + ((en && !m_full) ? 1 : 0)) % 32;
        occ    = (wnext - m_r2 + 32) % 32;
        e.addr  = 4'(wnext);
        e.gray  = to_gray(wnext);
        e.level = 5'(occ);
        e.full  = (occ == 16);
        e.af    = (occ >= 14);
        e.ovf   = en && m_full;
        sb.push_back(e);
        m_wcnt = wnext;
        m_full = e.full;
        m_r2   = m_r1;
        m_r1   = rbin % 32;
        @(posedge wr_clk);
        #1;
        got = sb.pop_front();
        chk("addr",  32'(wr_addr),        32'(got.addr));
        chk("gray",  32'(wr_ptr_gray),    32'(got.gray));
        chk("level", 32'(wr_level),       32'(got.level));
        chk("full",  32'(wr_full),        32'(got.full));
        chk("afull", 32'(wr_almost_full), 32'(got.af));
        chk("ovf",   32'(wr_overflow),    32'(got.ovf));
        $display("step en=%0b rd=%0d addr=%0d gray=%05b level=%0d full=%0b af=%0b ovf=%0b",
                 en, rbin, wr_addr, wr_ptr_gray, wr_level, wr_full, wr_almost_full, wr_overflow);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(wr_addr),        32'd0);
        chk({tag, "_gray"},  32'(wr_ptr_gray),    32'd0);
        chk({tag, "_level"}, 32'(wr_level),       32'd0);
        chk({tag, "_full"},  32'(wr_full),        32'd0);
        chk({tag, "_afull"}, 32'(wr_almost_full), 32'd0);
        chk({tag, "_ovf"},   32'(wr_overflow),    32'd0);
    endtask

    // Clock-driven process; cap the run in case a wait never returns.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] prev_gray;
        wr_rst_n    = 1'b0;
        wr_en       = 1'b0;
        rd_ptr_gray = '0;
        model_reset();
        #1;
        chk_all_zero("reset");
        @(posedge wr_clk);
        @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1;

        // Fill to full with the read pointer parked at zero; almost-full crossing along the way.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 0);
            if (i == 13) chk("af_at13", 32'(wr_almost_full), 32'd0);
            if (i == 14) begin
                chk("af_at14", 32'(wr_almost_full), 32'd1);
                chk("lvl_at14", 32'(wr_level), 32'd14);
            end
        end
        chk("fill_full",  32'(wr_full),     32'd1);
        chk("fill_level", 32'(wr_level),    32'd16);
        chk("fill_addr",  32'(wr_addr),     32'd0);
        chk("fill_gray",  32'(wr_ptr_gray), 32'b11000);

        // Overflow: one write attempt while full.
        step(1'b1, 0);
        chk("ovf_pulse", 32'(wr_overflow), 32'd1);
        chk("ovf_gray",  32'(wr_ptr_gray), 32'b11000);
        chk("ovf_level", 32'(wr_level),    32'd16);
        step(1'b0, 0);
        chk("ovf_clear", 32'(wr_overflow), 32'd0);

        // Release from full: read pointer moves to 1 before edge N.
        step(1'b0, 1);
        chk("rel_N",    32'(wr_full), 32'd1);
        step(1'b0, 1);
        chk("rel_N1",   32'(wr_full), 32'd1);
        step(1'b0, 1);
        chk("rel_N2",   32'(wr_full), 32'd0);
        chk("rel_lvl",  32'(wr_level), 32'd15);

        // Wrap-around: 40 writes from reset, read pointer trailing by at most 4.
        wr_rst_n = 1'b0;
        wr_en    = 1'b0;
        rd_ptr_gray = '0;
        model_reset();
        #1;
        chk_all_zero("rst2");
        @(posedge wr_clk);
        #1;
        wr_rst_n  = 1'b1;
        prev_gray = wr_ptr_gray;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, (i > 4) ? (i - 4) : 0);
            chk("wrap_nofull", 32'(wr_full), 32'd0);
            chk("wrap_1bit", 32'($countones(prev_gray ^ wr_ptr_gray)), 32'd1);
            prev_gray = wr_ptr_gray;
        end
        chk("wrap_gray", 32'(wr_ptr_gray), 32'b01100);
        chk("wrap_addr", 32'(wr_addr),     32'd8);

        // Reset mid-operation at level 10.
        wr_rst_n = 1'b0;
        wr_en    = 1'b0;
        rd_ptr_gray = '0;
        model_reset();
        #1;
        @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) step(1'b1, 0);
        chk("mid_lvl10", 32'(wr_level), 32'd10);
        #2;
        wr_rst_n = 1'b0;
        wr_en    = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge wr_clk);
        #1;
        chk_all_zero("midrst_hold");
        wr_rst_n = 1'b1;
        step(1'b1, 0);
        chk("after_addr",  32'(wr_addr),  32'd1);
        chk("after_level", 32'(wr_level), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
